// File: rtl/booth_iter_mul_front_pkg.sv
// Shared constants and encodings for the iterative radix-4 Booth multiplier front end.
// The default operand width, cycle count, FSM states and Booth digit decode live here.
package booth_iter_mul_front_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_NCYC  = DEF_WIDTH / 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        DIG_ZERO = 3'd0,
        DIG_POS1 = 3'd1,
        DIG_POS2 = 3'd2,
        DIG_NEG1 = 3'd3,
        DIG_NEG2 = 3'd4
    } booth_dig_e;

    // Window bits are {b[2j+1], b[2j], b[2j-1]}.
    function automatic booth_dig_e booth_decode(input logic [2:0] win);
        booth_dig_e dig;
        case (win)
            3'b001, 3'b010: dig = DIG_POS1;
            3'b011:         dig = DIG_POS2;
            3'b100:         dig = DIG_NEG2;
            3'b101, 3'b110: dig = DIG_NEG1;
            default:        dig = DIG_ZERO;
        endcase
        return dig;
    endfunction

    function automatic int ncyc_of(input int width);
        return width / 4;
    endfunction

endpackage

// File: rtl/booth_iter_mul_front_if.sv
// Operand/product bus of the Booth multiplier front end.
// A transfer happens on a rising edge where valid && ready; the sender holds its data until then.
interface booth_iter_mul_front_if
    import booth_iter_mul_front_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_a;
    logic [WIDTH-1:0]     in_b;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   out_sum;
    logic [2*WIDTH-1:0]   out_carry;
    logic                 busy;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_sum, out_carry, busy
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_sum, out_carry, busy
    );
endinterface

// File: rtl/booth_iter_mul_front_csa42.sv
// 4:2 compressor over 2*length-bit two's-complement inputs, widened by one bit internally.
// in1+in2+in3+in4+cin == out2 + 2*out1 + 2^(2*length+1)*cout.
module csa_4to2 #(
    parameter int length = 32
) (
    input  logic [2*length-1:0] in1,
    input  logic [2*length-1:0] in2,
    input  logic [2*length-1:0] in3,
    input  logic [2*length-1:0] in4,
    input  logic                cin,
    output logic [2*length:0]   out1,
    output logic [2*length:0]   out2,
    output logic                cout
);
    localparam int N = 2 * length + 1;

    logic [N-1:0] a, b, c, d;
    logic [N-1:0] s1, c1, ci;

    assign a = {in1[2*length-1], in1};
    assign b = {in2[2*length-1], in2};
    assign c = {in3[2*length-1], in3};
    assign d = {in4[2*length-1], in4};

    assign s1 = a ^ b ^ c;
    assign c1 = (a & b) | (a & c) | (b & c);

    // First-stage carries ripple exactly one position into the second stage.
    assign ci   = {c1[N-2:0], cin};
    assign out2 = s1 ^ d ^ ci;
    assign out1 = (s1 & d) | (s1 & ci) | (d & ci);
    assign cout = c1[N-1];
endmodule

// File: rtl/booth_iter_mul_front_pp_sel.sv
// Radix-4 Booth partial-product selector: picks 0, +M, +2M, -M or -2M from a 3-bit window.
// Output is unshifted; the caller aligns it to the digit weight.
module booth_pp_sel
    import booth_iter_mul_front_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [2:0]         win,
    input  logic [2*WIDTH-1:0] m,
    input  logic [2*WIDTH-1:0] m2,
    input  logic [2*WIDTH-1:0] mn,
    input  logic [2*WIDTH-1:0] m2n,
    output logic [2*WIDTH-1:0] pp
);
    booth_dig_e dig;

    always_comb begin
        dig = booth_decode(win);
        pp  = '0;
        case (dig)
            DIG_POS1: pp = m;
            DIG_POS2: pp = m2;
            DIG_NEG1: pp = mn;
            DIG_NEG2: pp = m2n;
            default:  pp = '0;
        endcase
    end
endmodule

// File: rtl/booth_iter_mul_front.sv
// Iterative radix-4 Booth multiplier front end: two partial products per cycle folded
// into a redundant sum/carry accumulator; the product is out_sum + out_carry mod 2^(2*WIDTH).
module booth_iter_mul_front
    import booth_iter_mul_front_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    booth_iter_mul_front_if.slave bus,
    output state_e                dbg_state
);
    localparam int PW   = 2 * WIDTH;
    localparam int NCYC = ncyc_of(WIDTH);
    localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;

    state_e state, state_nxt;

    logic [PW-1:0]    m_r, m2_r, mn_r, m2n_r;
    logic [WIDTH-1:0] b_sh;
    logic             b_last;
    logic [PW-1:0]    acc_sum, acc_carry;
    logic [CW-1:0]    cnt;

    logic [PW-1:0]    m_ext;
    logic [2:0]       win0, win1;
    logic [PW-1:0]    sel0, sel1, pp0, pp1;
    logic [PW:0]      c_out1, c_out2;
    logic             c_cout;
    logic             unused_bits;

    assign m_ext = {{WIDTH{bus.in_a[WIDTH-1]}}, bus.in_a};

    // b_sh is consumed four bits per cycle; b_last carries the overlap bit b[4*cnt-1].
    assign win0 = {b_sh[1:0], b_last};
    assign win1 = b_sh[3:1];

    booth_pp_sel #(.WIDTH(WIDTH)) u_sel0 (
        .win (win0),
        .m   (m_r),
        .m2  (m2_r),
        .mn  (mn_r),
        .m2n (m2n_r),
        .pp  (sel0)
    );

    booth_pp_sel #(.WIDTH(WIDTH)) u_sel1 (
        .win (win1),
        .m   (m_r),
        .m2  (m2_r),
        .mn  (mn_r),
        .m2n (m2n_r),
        .pp  (sel1)
    );

    assign pp0 = sel0 << {cnt, 2'b00};
    assign pp1 = sel1 << {cnt, 2'b10};

    csa_4to2 #(.length(WIDTH)) u_csa (
        .in1  (acc_sum),
        .in2  (acc_carry),
        .in3  (pp0),
        .in4  (pp1),
        .cin  (1'b0),
        .out1 (c_out1),
        .out2 (c_out2),
        .cout (c_cout)
    );

    // Bits at or above 2^PW are dropped; the accumulator is exact modulo 2^PW.
    assign unused_bits = ^{c_out2[PW], c_out1[PW:PW-1], c_cout};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (bus.in_valid) state_nxt = S_RUN;
            S_RUN:  if (cnt == CW'(NCYC - 1)) state_nxt = S_DONE;
            S_DONE: if (bus.out_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_r       <= '0;
            m2_r      <= '0;
            mn_r      <= '0;
            m2n_r     <= '0;
            b_sh      <= '0;
            b_last    <= 1'b0;
            acc_sum   <= '0;
            acc_carry <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        m_r       <= m_ext;
                        m2_r      <= m_ext << 1;
                        mn_r      <= -m_ext;
                        m2n_r     <= -(m_ext << 1);
                        b_sh      <= bus.in_b;
                        b_last    <= 1'b0;
                        acc_sum   <= '0;
                        acc_carry <= '0;
                        cnt       <= '0;
                    end
                end
                S_RUN: begin
                    acc_sum   <= c_out2[PW-1:0];
                    acc_carry <= {c_out1[PW-2:0], 1'b0};
                    cnt       <= cnt + 1'b1;
                    b_sh      <= b_sh >> 4;
                    b_last    <= b_sh[3];
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == S_IDLE);
    assign bus.out_valid = (state == S_DONE);
    assign bus.busy      = (state != S_IDLE);
    assign bus.out_sum   = acc_sum;
    assign bus.out_carry = acc_carry;
    assign dbg_state     = state;
endmodule

// File: tb/tb_booth_iter_mul_front.sv
// Bench for booth_iter_mul_front: directed corner products, backpressure, mid-run reset,
// input toggling, and randomized signed pairs against a plain-arithmetic product model.
module tb_booth_iter_mul_front;
  import booth_iter_mul_front_pkg::*;

  localparam int W  = 32;
  localparam int PW = 2 * W;
  localparam int NC = W / 4;

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  state_e dbg_state;

  booth_iter_mul_front_if #(.WIDTH(W)) mif ();

  booth_iter_mul_front #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (mif),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [PW-1:0] exp_q[$];
  int unsigned   acc_q[$];
  int            n_vec = 0;
  int            n_fail = 0;
  int            rdy_mode = 0;
  logic          prev_valid = 1'b0;

  task automatic check(input string name, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  task automatic flag_fail(input string name);
    n_vec++;
    n_fail++;
    $display("FAIL %s at %0t: bound expired or unexpected event", name, $time);
  endtask

  task automatic apply_reset(input int ncyc);
    rst_n = 1'b0;
    exp_q.delete();
    acc_q.delete();
    mif.in_valid = 1'b0;
    repeat (ncyc) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // ---------------- reference model ----------------
  function automatic logic [PW-1:0] golden(input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [PW-1:0] ea, eb;
    ea = $signed({{W{a[W-1]}}, a});
    eb = $signed({{W{b[W-1]}}, b});
    return ea * eb;
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 9))
      0: return '0;
      1: return W'(1);
      2: return '1;
      3: return {1'b1, {(W-1){1'b0}}};
      4: return {1'b0, {(W-1){1'b1}}};
      default: return W'($urandom);
    endcase
  endfunction

  // ---------------- drivers ----------------
  initial begin
    mif.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 0) mif.out_ready = 1'b1;
      else if (rdy_mode == 1) mif.out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [PW-1:0] exp);
    logic rdy;
    int   n;
    n = 0;
    mif.in_a = a;
    mif.in_b = b;
    mif.in_valid = 1'b1;
    forever begin
      @(negedge clk);
      rdy = mif.in_ready;
      @(posedge clk);
      #1;
      if (rdy) begin
        exp_q.push_back(exp);
        acc_q.push_back(cyc);
        break;
      end
      n++;
      if (n > 100) begin
        flag_fail("accept_timeout");
        break;
      end
    end
    mif.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) flag_fail("drain_timeout");
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      if (mif.out_valid) begin
        if (exp_q.size() == 0) begin
          flag_fail("unexpected_out_valid");
        end else begin
          check("product", mif.out_sum + mif.out_carry, exp_q[0]);
          check("in_ready_in_done", PW'(mif.in_ready), PW'(0));
          if (!prev_valid) check("latency", PW'(cyc - acc_q[0]), PW'(NC));
          if (mif.out_ready) begin
            void'(exp_q.pop_front());
            void'(acc_q.pop_front());
          end
        end
      end
      prev_valid = mif.out_valid;
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    logic [W-1:0] a, b;
    int n;
    mif.in_valid = 1'b0;
    mif.in_a = '0;
    mif.in_b = '0;
    apply_reset(3);

    @(negedge clk);
    check("reset_in_ready", PW'(mif.in_ready), PW'(1));
    check("reset_out_valid", PW'(mif.out_valid), PW'(0));
    check("reset_busy", PW'(mif.busy), PW'(0));
    check("reset_out_sum", mif.out_sum, PW'(0));
    check("reset_out_carry", mif.out_carry, PW'(0));
    check("reset_state", PW'(dbg_state), PW'(S_IDLE));
    @(posedge clk);
    #1;

    // directed products
    issue(W'(3), W'(5), 64'd15);
    @(negedge clk);
    check("busy_after_accept", PW'(mif.busy), PW'(1));
    wait_drain();
    issue('1, '1, 64'd1);
    wait_drain();
    issue(32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
    wait_drain();
    issue(32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000);
    wait_drain();

    // backpressure: hold out_ready low while DONE
    rdy_mode = 2;
    mif.out_ready = 1'b0;
    issue(32'h1234_5678, 32'hFEDC_BA98, golden(32'h1234_5678, 32'hFEDC_BA98));
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mif.out_valid && n < 50);
    if (!mif.out_valid) flag_fail("bp_wait_valid");
    repeat (5) begin
      @(negedge clk);
      check("bp_out_valid_held", PW'(mif.out_valid), PW'(1));
      check("bp_in_ready_low", PW'(mif.in_ready), PW'(0));
    end
    @(posedge clk);
    #1 mif.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_in_ready_after_hs", PW'(mif.in_ready), PW'(1));
    check("bp_out_valid_after_hs", PW'(mif.out_valid), PW'(0));
    check("bp_queue_popped", PW'(exp_q.size()), PW'(0));
    @(posedge clk);
    #1 rdy_mode = 0;

    // reset during RUN cycle 4 abandons the operation
    issue(32'h0000_ABCD, 32'h0000_1234, golden(32'h0000_ABCD, 32'h0000_1234));
    repeat (3) @(posedge clk);
    #3;
    apply_reset(2);
    repeat (12) begin
      @(negedge clk);
      check("abort_no_valid", PW'(mif.out_valid), PW'(0));
      check("abort_in_ready", PW'(mif.in_ready), PW'(1));
    end
    @(posedge clk);
    #1;
    issue(W'(7), -W'(9), 64'hFFFF_FFFF_FFFF_FFC1);
    wait_drain();

    // operand ports toggle during RUN; latched values must win
    for (int t = 0; t < 4; t++) begin
      a = pick();
      b = pick();
      issue(a, b, golden(a, b));
      repeat (NC) begin
        mif.in_valid = 1'b1;
        mif.in_a = W'($urandom);
        mif.in_b = W'($urandom);
        @(posedge clk);
        #1;
      end
      mif.in_valid = 1'b0;
      wait_drain();
    end

    // randomized signed pairs with output stalls
    rdy_mode = 1;
    for (int i = 0; i < 3000; i++) begin
      a = pick();
      b = pick();
      issue(a, b, golden(a, b));
    end
    wait_drain();
    rdy_mode = 0;
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
